reciprocal_lut_builder: RTL and testbench



---
 rtl/reciprocal_lut_builder_pkg.sv | 19 +
 rtl/reciprocal_lut_builder_seq_divider.sv | 87 ++++++++
 rtl/reciprocal_lut_builder.sv | 139 +++++++++++++
 tb/tb_reciprocal_lut_builder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reciprocal_lut_builder_pkg.sv
// Shared definitions for the reciprocal LUT builder and its divider.
//   FRAC_BITS     : fractional bits of the Q18.14 format
//   DIV_ITERS     : quotient bits produced by seq_divider (one per cycle)
//   build_state_e : build FSM states
package reciprocal_lut_builder_pkg;

  localparam int unsigned FRAC_BITS = 14;
  localparam int unsigned DIV_ITERS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_WRITE,
    ST_DONE
  } build_state_e;

endpackage

// File: rtl/reciprocal_lut_builder_seq_divider.sv
// seq_divider: 64/32 unsigned restoring divider, one quotient bit per cycle.
//   clk, reset_ni : clock, async active-low reset
//   start_i       : load operands (ignored while a division is running)
//   dividend_i    : 64-bit dividend
//   divisor_i     : 32-bit divisor (latched at start)
//   busy_o        : division in progress
//   done_o        : one-cycle pulse, 65 cycles after the start cycle
//   quotient_o    : floor quotient saturated to 32 bits; held until next start
module seq_divider
  import reciprocal_lut_builder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [63:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o
);

  logic [32:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic [32:0] trial;

  // Partial remainder stays below the divisor, so 33 bits hold the trial value.
  assign trial = {rem_q[31:0], quo_q[63]};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (!run_q) begin
      if (start_i) begin
        rem_d = '0;
        quo_d = dividend_i;
        dvs_d = divisor_i;
        cnt_d = 7'(DIV_ITERS);
        run_d = 1'b1;
      end
    end else begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = trial - {1'b0, dvs_q};
        quo_d = {quo_q[62:0], 1'b1};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[62:0], 1'b0};
      end
      cnt_d = cnt_q - 7'd1;
      if (cnt_q == 7'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = run_q;
  assign done_o     = done_q;
  // Divide-by-zero yields all ones and therefore also saturates.
  assign quotient_o = (|quo_q[63:32]) ? '1 : quo_q[31:0];

endmodule

// File: rtl/reciprocal_lut_builder.sv
// reciprocal_lut_builder: builds slope/intercept tables of f(x)=NUMERATOR/x
// (Q18.14) for the piecewise-linear reciprocal interpolator.
//   clk, reset_ni : clock, async active-low reset
//   start_i       : begin a build (sampled only when idle)
//   busy_o        : build in progress
//   done_o        : one-cycle pulse after the final table write
//   wr_en_o       : table write strobe
//   wr_addr_o     : table index j
//   wr_m_o        : slope m[j], signed Q18.14
//   wr_b_o        : intercept b[j], Q18.14
module reciprocal_lut_builder
  import reciprocal_lut_builder_pkg::*;
#(
  parameter logic [31:0] NUMERATOR                = 32'h100,
  parameter int unsigned END_INTERPOLATION_REGION = 65536,
  parameter int unsigned NB_SUBDIVISIONS          = 16384,
  localparam int unsigned SUBDIVISION_SIZE = END_INTERPOLATION_REGION / NB_SUBDIVISIONS,
  localparam int unsigned S                = $clog2(SUBDIVISION_SIZE),
  localparam int unsigned ADDR_W           = $clog2(NB_SUBDIVISIONS)
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_m_o,
  output logic [31:0]       wr_b_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [31:0] BV0   = NUMERATOR << FRAC_BITS;

  build_state_e      state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [31:0]       prev_q, prev_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       m_q, m_d;
  logic [31:0]       b_q, b_d;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [31:0]       div_quo;
  logic [31:0]       div_divisor;
  logic signed [31:0] diff;
  logic              last_entry;

  // X_i = (i * SUBDIVISION_SIZE) << FRAC_BITS; SUBDIVISION_SIZE is 2^S.
  assign div_divisor = 32'(idx_q) << (S + FRAC_BITS);
  assign diff        = $signed(div_quo - prev_q);
  assign last_entry  = (idx_q == CNT_W'(NB_SUBDIVISIONS));

  seq_divider u_div (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .start_i    (div_start),
    .dividend_i (64'(NUMERATOR) << FRAC_BITS),
    .divisor_i  (div_divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start_i) state_d = ST_INIT;
      ST_INIT:      state_d = ST_DIV_START;
      ST_DIV_START: state_d = ST_DIV_WAIT;
      ST_DIV_WAIT:  if (div_done) state_d = ST_WRITE;
      ST_WRITE:     state_d = last_entry ? ST_DONE : ST_DIV_START;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done_o    = (state_q == ST_DONE);
    wr_en_o   = (state_q == ST_WRITE);
    div_start = (state_q == ST_DIV_START);
  end

  // Write payload is captured as the quotient arrives so it is stable
  // throughout the WRITE cycle and held afterwards.
  always_comb begin
    idx_d  = idx_q;
    prev_d = prev_q;
    addr_d = addr_q;
    m_d    = m_q;
    b_d    = b_q;
    unique case (state_q)
      ST_INIT: begin
        prev_d = BV0;
        idx_d  = CNT_W'(1);
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          addr_d = ADDR_W'(idx_q - CNT_W'(1));
          b_d    = prev_q;
          m_d    = 32'(diff >>> S);
        end
      end
      ST_WRITE: begin
        prev_d = div_quo;
        if (!last_entry) idx_d = idx_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q  <= '0;
      prev_q <= '0;
      addr_q <= '0;
      m_q    <= '0;
      b_q    <= '0;
    end else begin
      idx_q  <= idx_d;
      prev_q <= prev_d;
      addr_q <= addr_d;
      m_q    <= m_d;
      b_q    <= b_d;
    end
  end

  assign wr_addr_o = addr_q;
  assign wr_m_o    = m_q;
  assign wr_b_o    = b_q;

endmodule

// File: tb/tb_reciprocal_lut_builder.sv
// Self-checking bench for reciprocal_lut_builder and its seq_divider.
module tb_reciprocal_lut_builder;

  localparam logic [31:0] S_NUM = 32'h100;
  localparam int unsigned S_END = 16;
  localparam int unsigned S_NB  = 4;
  localparam logic [31:0] B_NUM = 32'h0003_0000;
  localparam int unsigned B_END = 65536;
  localparam int unsigned B_NB  = 256;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small-table DUT
  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_wr_en;
  logic [1:0]  s_addr;
  logic [31:0] s_m, s_b;
  // larger-table DUT
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_wr_en;
  logic [7:0]  b_addr;
  logic [31:0] b_m, b_b;
  // stand-alone divider
  logic        d_start = 1'b0;
  logic [63:0] d_dividend = '0;
  logic [31:0] d_divisor = '0;
  logic        d_busy, d_done;
  logic [31:0] d_quo;

  reciprocal_lut_builder #(.NUMERATOR(S_NUM), .END_INTERPOLATION_REGION(S_END),
                           .NB_SUBDIVISIONS(S_NB)) u_small (
    .clk(clk), .reset_ni(reset_ni), .start_i(s_start), .busy_o(s_busy),
    .done_o(s_done), .wr_en_o(s_wr_en), .wr_addr_o(s_addr), .wr_m_o(s_m), .wr_b_o(s_b));

  reciprocal_lut_builder #(.NUMERATOR(B_NUM), .END_INTERPOLATION_REGION(B_END),
                           .NB_SUBDIVISIONS(B_NB)) u_big (
    .clk(clk), .reset_ni(reset_ni), .start_i(b_start), .busy_o(b_busy),
    .done_o(b_done), .wr_en_o(b_wr_en), .wr_addr_o(b_addr), .wr_m_o(b_m), .wr_b_o(b_b));

  seq_divider u_div (
    .clk(clk), .reset_ni(reset_ni), .start_i(d_start), .dividend_i(d_dividend),
    .divisor_i(d_divisor), .busy_o(d_busy), .done_o(d_done), .quotient_o(d_quo));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: sample value f(X_i) in Q18.14 straight from the formulas.
  function automatic logic [31:0] ref_bv(input logic [31:0] num, input int unsigned endr,
                                         input int unsigned nb, input int unsigned i);
    logic [63:0] x, q;
    if (i == 0) return num << 14;
    x = 64'(i) * 64'(endr / nb) * 64'd16384;
    q = (64'(num) * 64'd16384) / x;
    return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  // Slope: 32-bit wrapped difference, then floor division by the segment width.
  function automatic logic [31:0] ref_m(input logic [31:0] num, input int unsigned endr,
                                        input int unsigned nb, input int unsigned j);
    longint diff, d, q;
    diff = longint'($signed(ref_bv(num, endr, nb, j + 1) - ref_bv(num, endr, nb, j)));
    d = longint'(endr / nb);
    q = diff / d;
    if ((diff % d) != 0 && diff < 0) q = q - 1;
    return q[31:0];
  endfunction

  // Observation of the small DUT.
  longint      s_wcyc[$];
  logic [31:0] s_waddr[$], s_wm[$], s_wb[$];
  longint      s_dcyc[$];
  int unsigned s_b2b = 0;
  longint      s_last = -10;
  always @(negedge clk) begin
    if (s_wr_en) begin
      if (cyc == s_last + 1) s_b2b++;
      s_last = cyc;
      s_wcyc.push_back(cyc);
      s_waddr.push_back(32'(s_addr));
      s_wm.push_back(s_m);
      s_wb.push_back(s_b);
    end
    if (s_done) s_dcyc.push_back(cyc);
  end

  // Observation of the larger DUT.
  logic [31:0] big_m[B_NB];
  logic [31:0] big_b[B_NB];
  int unsigned big_cnt = 0, big_order = 0, big_b2b = 0, big_done = 0;
  longint      big_last = -10;
  always @(negedge clk) begin
    if (b_wr_en) begin
      if (32'(b_addr) != big_cnt) big_order++;
      if (cyc == big_last + 1) big_b2b++;
      big_last = cyc;
      if (big_cnt < B_NB) begin
        big_m[b_addr] = b_m;
        big_b[b_addr] = b_b;
      end
      big_cnt++;
    end
    if (b_done) big_done++;
  end

  task automatic clear_small;
    s_wcyc.delete(); s_waddr.delete(); s_wm.delete(); s_wb.delete(); s_dcyc.delete();
    s_b2b = 0;
  endtask

  task automatic check_small_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(s_busy), 64'd0);
    check({tag, "_done"}, 64'(s_done), 64'd0);
    check({tag, "_wr_en"}, 64'(s_wr_en), 64'd0);
    check({tag, "_addr"}, 64'(s_addr), 64'd0);
    check({tag, "_m"}, 64'(s_m), 64'd0);
    check({tag, "_b"}, 64'(s_b), 64'd0);
  endtask

  task automatic verify_small_build(input string tag, input longint k, input bit timing);
    check({tag, "_nwr"}, 64'(s_wcyc.size()), 64'(S_NB));
    check({tag, "_ndone"}, 64'(s_dcyc.size()), 64'd1);
    check({tag, "_b2b"}, 64'(s_b2b), 64'd0);
    for (int j = 0; j < S_NB; j++) begin
      if (j < s_wcyc.size()) begin
        check($sformatf("%s_addr%0d", tag, j), 64'(s_waddr[j]), 64'(j));
        check($sformatf("%s_m%0d", tag, j), 64'(s_wm[j]), 64'(ref_m(S_NUM, S_END, S_NB, j)));
        check($sformatf("%s_b%0d", tag, j), 64'(s_wb[j]), 64'(ref_bv(S_NUM, S_END, S_NB, j)));
        if (timing)
          check($sformatf("%s_wcyc%0d", tag, j), 64'(s_wcyc[j] - k), 64'(68 + 67 * j));
      end
    end
    if (timing && s_dcyc.size() > 0)
      check({tag, "_dcyc"}, 64'(s_dcyc[0] - k), 64'd270);
  endtask

  task automatic wait_small_done(input string tag, input int budget);
    int n = 0;
    while (!s_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!s_done) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic [63:0] dvd, input logic [31:0] dvs);
    longint k;
    logic [63:0] q;
    @(negedge clk);
    d_dividend = dvd;
    d_divisor  = dvs;
    d_start    = 1'b1;
    k = cyc;
    @(negedge clk);
    d_start = 1'b0;
    d_dividend = ~dvd;
    d_divisor  = ~dvs;
    check({tag, "_busy"}, 64'(d_busy), 64'd1);
    while (!d_done && (cyc - k) < 200) @(negedge clk);
    q = (dvs == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : dvd / 64'(dvs);
    check({tag, "_lat"}, 64'(cyc - k), 64'd65);
    check({tag, "_quo"}, 64'(d_quo), (q > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : q);
  endtask

  initial begin
    longint k;
    int n;
    int unsigned j;

    repeat (3) @(negedge clk);
    check_small_outputs_zero("rst");
    reset_ni = 1'b1;
    @(negedge clk);

    // Divider unit checks, directed then random.
    run_div("div64", 64'h1 << 22, 32'h1 << 16);
    run_div("divovf", 64'h1 << 60, 32'h1 << 14);
    for (int i = 0; i < 6; i++)
      run_div($sformatf("divrnd%0d", i), {$urandom, $urandom} >> $urandom_range(0, 40),
              $urandom | 32'h1);

    // Full build with cycle-accurate timing.
    repeat ($urandom_range(1, 20)) @(negedge clk);
    clear_small();
    s_start = 1'b1;
    k = cyc;
    check("idle_busy", 64'(s_busy), 64'd0);
    @(negedge clk);
    s_start = 1'b0;
    check("busy_rise", 64'(s_busy), 64'd1);
    wait_small_done("b1", 400);
    check("busy_at_done", 64'(s_busy), 64'd0);
    repeat (5) @(negedge clk);
    verify_small_build("b1", k, 1'b1);

    // start_i held for a whole build, then a fresh build.
    clear_small();
    s_start = 1'b1;
    k = cyc;
    @(negedge clk);
    wait_small_done("b2", 400);
    s_start = 1'b0;
    repeat (300) @(negedge clk);
    verify_small_build("b2", k, 1'b1);
    clear_small();
    s_start = 1'b1;
    k = cyc;
    @(negedge clk);
    s_start = 1'b0;
    wait_small_done("b3", 400);
    repeat (3) @(negedge clk);
    verify_small_build("b3", k, 1'b1);

    // Reset in the middle of the third entry's division.
    clear_small();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_wcyc.size() < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_writes", 64'(s_wcyc.size()), 64'd2);
    repeat ($urandom_range(3, 50)) @(negedge clk);
    check("pre_rst_busy", 64'(s_busy), 64'd1);
    #2 reset_ni = 1'b0;
    #1 check_small_outputs_zero("midrst");
    @(negedge clk);
    reset_ni = 1'b1;
    clear_small();
    repeat (1000) @(negedge clk);
    check("post_rst_writes", 64'(s_wcyc.size()), 64'd0);
    check("post_rst_busy", 64'(s_busy), 64'd0);

    // Larger table, spot-checked at random indices plus both ends.
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 67 * B_NB + 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("big_nwr", 64'(big_cnt), 64'(B_NB));
    check("big_order", 64'(big_order), 64'd0);
    check("big_b2b", 64'(big_b2b), 64'd0);
    check("big_done", 64'(big_done), 64'd1);
    for (int i = 0; i < 42; i++) begin
      j = (i == 0) ? 0 : (i == 1) ? B_NB - 1 : $urandom_range(0, B_NB - 1);
      check($sformatf("big_m%0d", j), 64'(big_m[j]), 64'(ref_m(B_NUM, B_END, B_NB, j)));
      check($sformatf("big_b%0d", j), 64'(big_b[j]), 64'(ref_bv(B_NUM, B_END, B_NB, j)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
